decode_queue: RTL and testbench

- N-wide instruction buffer between fetch and `stage_decode`.
- Absorbs fetch bursts and decouples fetch from a variable-width downstream dispatch.
- Accepts up to N IF_ID_PACKETs per cycle, compacts valid lanes, and presents the oldest N entries in order.
- Supports a single-cycle squash on branch mispredict.

---
 rtl/decode_queue_pkg.sv | 15 +
 rtl/decode_queue_lane_compactor.sv | 38 +++
 rtl/decode_queue.sv | 115 +++++++++++
 tb/tb_decode_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared lane width, queue depth and fetch/decode packet type for the decode queue.
// Stands in for the sys_defs.svh definitions (IF_ID_PACKET, `N, DQ_DEPTH).
package decode_queue_pkg;

    localparam int NUM_LANES = 2;
    localparam int DQ_DEPTH  = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } if_id_packet_t;

endpackage

// File: rtl/decode_queue_lane_compactor.sv
// Combinational lane compactor: packs the valid lanes of an N-wide fetch group
// into the low lanes, preserving lane order, and reports how many there are.
module lane_compactor
    import decode_queue_pkg::*;
#(
    parameter int N      = NUM_LANES,
    parameter int DISP_W = $clog2(N + 1)
) (
    input  if_id_packet_t [N-1:0] lanes,
    output if_id_packet_t [N-1:0] dense,
    output logic [DISP_W-1:0]     cnt
);

    logic [DISP_W-1:0] rank [N];

    // rank[i] is the number of valid lanes below lane i, i.e. its dense slot.
    always_comb begin : rank_calc
        logic [DISP_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            rank[i] = acc;
            acc     = acc + DISP_W'(lanes[i].valid);
        end
        cnt = acc;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        dense = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (lanes[i].valid && rank[i] == DISP_W'(j))
                    dense[j] = lanes[i];
            end
        end
    end

endmodule

// File: rtl/decode_queue.sv
// N-wide circular instruction buffer between fetch and decode, with single-cycle squash.
// Define DECODE_QUEUE_BYPASS_EN to forward fetch lanes straight to decode when the queue is empty.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int N      = NUM_LANES,
    parameter int DEPTH  = DQ_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int DISP_W = $clog2(N + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  if_id_packet_t [N-1:0] if_id_packet,
    input  logic [DISP_W-1:0]     num_dispatch,
    output if_id_packet_t [N-1:0] out_packet,
    output logic [N-1:0]          out_valid,
    output logic [CNT_W-1:0]      free_slots,
    output logic                  if_stall
);

    localparam int PTR_W = $clog2(DEPTH);

    if_id_packet_t         mem [DEPTH];
    logic [PTR_W-1:0]      head, tail;
    logic [CNT_W-1:0]      count;

    if_id_packet_t [N-1:0] cmp_lanes;
    logic [DISP_W-1:0]     cmp_cnt;
    if_id_packet_t [N-1:0] enq_lanes;
    logic [CNT_W-1:0]      enq_cnt, enq_amt, deq_cnt, nd_ext;
    logic                  enq_ok;

    lane_compactor #(.N(N), .DISP_W(DISP_W)) u_compactor (
        .lanes (if_id_packet),
        .dense (cmp_lanes),
        .cnt   (cmp_cnt)
    );

    // Stall and accept decisions see only registered state, never num_dispatch.
    assign free_slots = CNT_W'(DEPTH) - count;
    assign if_stall   = free_slots < CNT_W'(N);
    assign enq_ok     = !squash && !if_stall;
    assign enq_amt    = enq_ok ? enq_cnt : '0;
    assign nd_ext     = CNT_W'(num_dispatch);
    assign deq_cnt    = (nd_ext > count) ? count : nd_ext;

`ifdef DECODE_QUEUE_BYPASS_EN
    logic             bypass;
    logic [CNT_W-1:0] skip;

    assign bypass = (count == '0) && !squash;

    // Lanes decode takes straight off the bypass are dropped from the front of the enqueue group.
    always_comb begin
        skip = '0;
        if (bypass)
            skip = (nd_ext > CNT_W'(cmp_cnt)) ? CNT_W'(cmp_cnt) : nd_ext;
        enq_cnt   = CNT_W'(cmp_cnt) - skip;
        enq_lanes = '0;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) begin
                if (CNT_W'(k) == CNT_W'(j) + skip)
                    enq_lanes[j] = cmp_lanes[k];
            end
        end
    end
`else
    assign enq_cnt   = CNT_W'(cmp_cnt);
    assign enq_lanes = cmp_lanes;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
            head  <= head + PTR_W'(deq_cnt);
            tail  <= tail + PTR_W'(enq_amt);
            count <= count + enq_amt - deq_cnt;
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are masked by out_valid.
    always_ff @(posedge clock) begin
        if (enq_ok) begin
            for (int j = 0; j < N; j++) begin
                if (CNT_W'(j) < enq_cnt)
                    mem[tail + PTR_W'(j)] <= enq_lanes[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_packet[i] = mem[head + PTR_W'(i)];
            out_valid[i]  = CNT_W'(i) < count;
        end
`ifdef DECODE_QUEUE_BYPASS_EN
        if (bypass) begin
            for (int i = 0; i < N; i++) begin
                out_packet[i] = cmp_lanes[i];
                out_valid[i]  = DISP_W'(i) < cmp_cnt;
            end
        end
`endif
    end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue (default build): a driver updates a PC-queue model
// and pushes the expected registered view; a monitor pops and compares after each edge.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int N      = NUM_LANES;
    localparam int DEPTH  = DQ_DEPTH;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DISP_W = $clog2(N + 1);

    typedef struct packed {
        logic [7:0]            count;
        logic [N-1:0][31:0]    pcs;
    } exp_t;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  squash;
    if_id_packet_t [N-1:0] if_id_packet;
    logic [DISP_W-1:0]     num_dispatch;
    if_id_packet_t [N-1:0] out_packet;
    logic [N-1:0]          out_valid;
    logic [CNT_W-1:0]      free_slots;
    logic                  if_stall;

    decode_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .if_id_packet (if_id_packet),
        .num_dispatch (num_dispatch),
        .out_packet   (out_packet),
        .out_valid    (out_valid),
        .free_slots   (free_slots),
        .if_stall     (if_stall)
    );

    always #5 clock = ~clock;

    logic [31:0] model_q [$];
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          mon_cyc  = 0;
    logic [31:0] next_pc  = 32'h100;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic push_expect();
        exp_t e;
        e.count = 8'(model_q.size());
        e.pcs   = '0;
        for (int i = 0; i < N; i++)
            if (i < model_q.size()) e.pcs[i] = model_q[i];
        exp_q.push_back(e);
    endtask

    function automatic logic [N-1:0][31:0] lanes2(input logic [31:0] l0, input logic [31:0] l1);
        logic [N-1:0][31:0] p;
        p[0] = l0;
        p[1] = l1;
        return p;
    endfunction

    // One cycle of stimulus; the model is a plain FIFO of PCs.
    task automatic step(input logic [N-1:0] vmask, input logic [N-1:0][31:0] pcs,
                        input int nd, input logic sq, output logic accepted);
        logic stall_pre;
        int   deq;
        for (int i = 0; i < N; i++) begin
            if_id_packet[i].valid = vmask[i];
            if_id_packet[i].pc    = pcs[i];
            if_id_packet[i].inst  = ~pcs[i];
            if_id_packet[i].npc   = pcs[i] + 32'd4;
        end
        num_dispatch = DISP_W'(nd);
        squash       = sq;
        accepted     = 1'b0;
        if (sq) begin
            model_q.delete();
        end else begin
            stall_pre = (DEPTH - model_q.size()) < N;
            deq = (nd < model_q.size()) ? nd : model_q.size();
            repeat (deq) void'(model_q.pop_front());
            if (!stall_pre) begin
                for (int i = 0; i < N; i++)
                    if (vmask[i]) model_q.push_back(pcs[i]);
                accepted = 1'b1;
            end
        end
        push_expect();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_q.delete();
        push_expect();
        @(negedge clock);
        push_expect();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic seq_pair(input int nd, output logic acc);
        step(2'b11, lanes2(next_pc, next_pc + 32'd4), nd, 1'b0, acc);
        if (acc) next_pc = next_pc + 32'd8;
    endtask

    // Monitor: compares the registered view one delta after each rising edge.
    initial begin
        forever begin
            exp_t        e;
            int          cnt;
            logic [N-1:0] vexp;
            @(posedge clock);
            #1;
            mon_cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                cnt = int'(e.count);
                for (int i = 0; i < N; i++) vexp[i] = (i < cnt);
                check("out_valid", mon_cyc, 32'(out_valid), 32'(vexp));
                check("free_slots", mon_cyc, 32'(free_slots), 32'(DEPTH - cnt));
                check("if_stall", mon_cyc, 32'(if_stall), 32'((DEPTH - cnt) < N));
                for (int i = 0; i < N; i++)
                    if (i < cnt) check("out_pc", mon_cyc, out_packet[i].pc, e.pcs[i]);
            end
        end
    end

    initial begin
        logic               acc;
        logic [N-1:0]       pmask;
        logic [N-1:0][31:0] ppcs;
        logic               have_pend;
        logic               sq;
        int                 budget;

        reset        = 1'b0;
        squash       = 1'b0;
        num_dispatch = '0;
        if_id_packet = '0;
        do_reset();

        // Two lanes in, nothing out; then a sparse group while draining.
        step(2'b11, lanes2(32'h0, 32'h4), 0, 1'b0, acc);
        step(2'b10, lanes2(32'hdead, 32'h8), 2, 1'b0, acc);

        // Fill to full, drop a group while dispatching two, then hit the free==1 stall.
        step(2'b00, lanes2(32'h0, 32'h0), 1, 1'b0, acc);
        repeat (4) seq_pair(0, acc);
        step(2'b11, lanes2(32'h900, 32'h904), 2, 1'b0, acc);
        step(2'b00, lanes2(32'h0, 32'h0), 0, 1'b0, acc);
        step(2'b01, lanes2(next_pc, 32'h0), 0, 1'b0, acc);
        next_pc = next_pc + 32'd4;
        step(2'b11, lanes2(32'h910, 32'h914), 0, 1'b0, acc);

        // Steady enqueue-2 / dequeue-2 across pointer wrap.
        repeat (20) seq_pair(2, acc);

        // Squash at count 5 with a valid group on the inputs.
        step(2'b00, lanes2(32'h0, 32'h0), 0, 1'b1, acc);
        seq_pair(0, acc);
        seq_pair(0, acc);
        step(2'b01, lanes2(next_pc, 32'h0), 0, 1'b0, acc);
        next_pc = next_pc + 32'd4;
        step(2'b11, lanes2(32'hA00, 32'hA04), 1, 1'b1, acc);
        step(2'b00, lanes2(32'h0, 32'h0), 2, 1'b0, acc);

        // Reset in the middle of traffic.
        seq_pair(0, acc);
        seq_pair(0, acc);
        do_reset();

        // Randomized traffic; a stalled group is replayed, a squashed one is dropped.
        have_pend = 1'b0;
        pmask     = '0;
        ppcs      = '0;
        for (int c = 0; c < 400; c++) begin
            if (!have_pend) begin
                pmask = N'($urandom);
                for (int i = 0; i < N; i++) begin
                    if (pmask[i]) begin
                        ppcs[i] = next_pc;
                        next_pc = next_pc + 32'd4;
                    end else begin
                        ppcs[i] = 32'hdead_0000 | 32'(i);
                    end
                end
                have_pend = 1'b1;
            end
            sq = ($urandom_range(0, 24) == 0);
            step(pmask, ppcs, int'($urandom_range(0, N)), sq, acc);
            if (acc || sq) have_pend = 1'b0;
        end

        squash       = 1'b0;
        if_id_packet = '0;
        num_dispatch = '0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clock);
            budget++;
        end
        check("scoreboard_drain", mon_cyc, 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
